// File: rtl/multi_channel_timer.sv
// multi_channel_timer: NUM_CH one-shot/periodic/edge-PWM/centre-PWM channels on one shared prescaler.
// Define TIMER_CAPTURE_EN to add per-channel input capture (capture_in/capture_val).
module multi_channel_timer #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PRESC_W-1:0]      prescale,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       start,
    input  logic [2*NUM_CH-1:0]     mode,
    input  logic [CNT_W*NUM_CH-1:0] load,
    input  logic [CNT_W*NUM_CH-1:0] compare,
    input  logic [NUM_CH-1:0]       irq_clear,
`ifdef TIMER_CAPTURE_EN
    input  logic [NUM_CH-1:0]       capture_in,
    output logic [CNT_W*NUM_CH-1:0] capture_val,
`endif
    output logic [NUM_CH-1:0]       running,
    output logic [NUM_CH-1:0]       timeout,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic [NUM_CH-1:0]       irq_status,
    output logic                    irq
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;

    assign tick = presc_cnt >= prescale;
    assign irq  = |irq_status;

    always_ff @(posedge clk or posedge reset)
        if (reset) presc_cnt <= '0;
        else presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] ld, cmp, cnt;
        logic [1:0]       md;
        state_t           st;
        logic             up, tmo, pwm, irq_r, set;

        assign ld            = load[CNT_W*i +: CNT_W];
        assign cmp           = compare[CNT_W*i +: CNT_W];
        assign md            = mode[2*i +: 2];
        assign running[i]    = st == RUN;
        assign timeout[i]    = tmo;
        assign pwm_out[i]    = pwm;
        assign irq_status[i] = irq_r;

        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                st  <= IDLE;
                cnt <= '0;
                up  <= 1'b0;
                tmo <= 1'b0;
                pwm <= 1'b0;
            end else begin
                tmo <= 1'b0;
                if (!enable[i]) begin
                    st  <= IDLE;
                    cnt <= '0;
                    up  <= 1'b0;
                    pwm <= 1'b0;
                end else if (start[i]) begin
                    st  <= RUN;
                    cnt <= ld;
                    up  <= 1'b0;
                end else if (st == RUN && tick) begin
                    pwm <= md[1] && cnt < cmp;
                    if (md != 2'b11) begin
                        up  <= 1'b0;
                        tmo <= cnt == '0;
                        cnt <= (cnt != '0) ? cnt - CNT_W'(1) : (md == 2'b00 ? '0 : ld);
                        if (cnt == '0 && md == 2'b00) st <= DONE;
                    end else if (!up) begin
                        tmo <= cnt == '0;
                        if (cnt != '0) cnt <= cnt - CNT_W'(1);
                        else if (ld != '0) begin
                            // turn around at zero on the same tick so the period is 2*load
                            up  <= 1'b1;
                            cnt <= CNT_W'(1);
                        end
                    end else if (cnt >= ld) begin
                        up  <= 1'b0;
                        cnt <= cnt - CNT_W'(1);
                    end else cnt <= cnt + CNT_W'(1);
                end
            end

`ifdef TIMER_CAPTURE_EN
        logic [2:0]       sync;
        logic [CNT_W-1:0] cap;
        logic             cap_hit;

        assign cap_hit = sync[1] && !sync[2] && st == RUN;
        assign set     = tmo | cap_hit;
        assign capture_val[CNT_W*i +: CNT_W] = cap;

        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                sync <= '0;
                cap  <= '0;
            end else begin
                sync <= {sync[1:0], capture_in[i]};
                if (cap_hit) cap <= cnt;
            end
`else
        assign set = tmo;
`endif

        // set wins over a simultaneous clear
        always_ff @(posedge clk or posedge reset)
            if (reset) irq_r <= 1'b0;
            else irq_r <= (irq_r & ~irq_clear[i]) | set;
    end
endmodule
